// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: display-side signal bundle of the VGA timing generator.
//   rgb_in     : pixel colour from the drawing modules (into the generator)
//   row, col   : stage-0 line / pixel counters
//   visible    : stage-0 active-area flag
//   frame_tick : stage-0 one-cycle pulse at the start of vertical blanking
//   hsync,vsync: stage-1 sync outputs to the monitor
//   rgb_out    : stage-1 colour to the DAC/pins
// master = the timing generator, slave = the drawing/consumer side.
interface vga_timing_gen_if;
  logic [2:0] rgb_in;
  logic [9:0] row;
  logic [9:0] col;
  logic       visible;
  logic       frame_tick;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb_out;

  modport master (
    input  rgb_in,
    output row, col, visible, frame_tick, hsync, vsync, rgb_out
  );

  modport slave (
    output rgb_in,
    input  row, col, visible, frame_tick, hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Stage 0 is a free-running col/row counter pair with combinational decodes
// (visible, frame_tick, raw syncs). Stage 1 registers the syncs and the
// blanked colour so they leave the block one clock after row/col.
// Ports:
//   clock : pixel clock, rising edge
//   reset : synchronous, active-high
//   bus   : vga_timing_gen_if.master (rgb_in in; counters, decodes, syncs, rgb_out out)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned RGB_W        = 3;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic col_wrap;
  logic row_wrap;
  logic visible_s0;
  logic frame_tick_s0;
  logic hsync_s0;
  logic vsync_s0;

  // Stage 0: counter next-state and raster decodes
  always_comb begin
    col_wrap      = (col_q == CNT_W'(H_TOTAL - 1));
    row_wrap      = (row_q == CNT_W'(V_TOTAL - 1));
    col_d         = col_wrap ? '0 : col_q + CNT_W'(1);
    row_d         = row_q;
    if (col_wrap) begin
      row_d = row_wrap ? '0 : row_q + CNT_W'(1);
    end

    visible_s0    = (col_q < CNT_W'(H_VISIBLE)) && (row_q < CNT_W'(V_VISIBLE));
    frame_tick_s0 = (row_q == CNT_W'(V_VISIBLE)) && (col_q == '0);
    hsync_s0      = (col_q >= CNT_W'(H_SYNC_START)) && (col_q < CNT_W'(H_SYNC_END));
    vsync_s0      = (row_q >= CNT_W'(V_SYNC_START)) && (row_q < CNT_W'(V_SYNC_END));
  end

  // Stage 1 next values: polarity-mapped syncs and blanked colour
  always_comb begin
    hsync_d = hsync_s0 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = vsync_s0 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    rgb_d   = visible_s0 ? bus.rgb_in : '0;
  end

  // State registers for both stages
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.visible    = visible_s0;
  assign bus.frame_tick = frame_tick_s0;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Three instances run in lockstep: A with default 640x480 timing, B and C with
// a tiny raster (15x10) of opposite sync polarity so whole frames fit in a short run.
// Expected stage-1 outputs are pushed when stimulus is driven and popped one edge later.
module tb_vga_timing_gen;

  typedef struct {
    int   hv, hf, hs, hb, vv, vf, vs, vb;
    logic sa;
  } cfg_t;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       vis;
    logic       ft;
    logic       hs;
    logic       vs;
  } s0_t;

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  cfg_t cfg_b = '{8, 2, 3, 2, 5, 1, 2, 2, 1'b0};
  cfg_t cfg_c = '{8, 2, 3, 2, 5, 1, 2, 2, 1'b1};

  logic       clk;
  logic       rst;
  logic [2:0] rgb_drv;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  assign if_a.rgb_in = rgb_drv;
  assign if_b.rgb_in = rgb_drv;
  assign if_c.rgb_in = rgb_drv;

  vga_timing_gen dut_a (.clock(clk), .reset(rst), .bus(if_a));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b0)
  ) dut_b (.clock(clk), .reset(rst), .bus(if_b));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
  ) dut_c (.clock(clk), .reset(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;   // edges since the last reset edge
  int g       = 0;   // global edge counter
  logic cur_rst;

  logic [4:0] sb_a[$];
  logic [4:0] sb_b[$];
  logic [4:0] sb_c[$];

  localparam int WIN0 = 1000;
  int a_hs = 0, a_vs = 0;
  int b_ft = 0, b_hs = 0, b_vs = 0;
  int c_ft = 0, c_hs = 0, c_vs = 0;
  logic track_ft = 1'b0;
  int   ft_lat   = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, g);
    end
  endtask

  // Reference raster position from the edge count since reset
  function automatic s0_t model_s0(input cfg_t c, input int cyc);
    int ht, vt, cc, rr;
    s0_t m;
    ht    = c.hv + c.hf + c.hs + c.hb;
    vt    = c.vv + c.vf + c.vs + c.vb;
    cc    = cyc % ht;
    rr    = (cyc / ht) % vt;
    m.row = 10'(rr);
    m.col = 10'(cc);
    m.vis = (cc < c.hv) && (rr < c.vv);
    m.ft  = (rr == c.vv) && (cc == 0);
    m.hs  = (cc >= c.hv + c.hf) && (cc < c.hv + c.hf + c.hs);
    m.vs  = (rr >= c.vv + c.vf) && (rr < c.vv + c.vf + c.vs);
    return m;
  endfunction

  // Value {hsync, vsync, rgb_out} expected after the next edge
  function automatic logic [4:0] s1_exp(input cfg_t c, input s0_t m,
                                        input logic [2:0] rgb, input logic r);
    if (r) return {~c.sa, ~c.sa, 3'b000};
    return {(m.hs ? c.sa : ~c.sa), (m.vs ? c.sa : ~c.sa), (m.vis ? rgb : 3'b000)};
  endfunction

  task automatic eval_inst(input string nm, input s0_t m,
                           input logic [9:0] row, input logic [9:0] col,
                           input logic vis, input logic ft,
                           input logic hs, input logic vs, input logic [2:0] rgb,
                           input logic [4:0] e1);
    check({nm, "_rowcol"}, 32'({row, col}), 32'({m.row, m.col}));
    check({nm, "_vis_ft"}, 32'({vis, ft}), 32'({m.vis, m.ft}));
    check({nm, "_stage1"}, 32'({hs, vs, rgb}), 32'(e1));
  endtask

  // One clock: sample and score all instances, then drive the next reset/colour
  task automatic tick(input logic nrst, input logic [2:0] nrgb);
    s0_t ma, mb, mc;
    logic [4:0] ea, eb, ec;
    @(posedge clk);
    #1;
    n = cur_rst ? 0 : n + 1;
    g++;
    ma = model_s0(cfg_a, n);
    mb = model_s0(cfg_b, n);
    mc = model_s0(cfg_c, n);
    if (sb_a.size() == 0) begin check("A_sb_empty", 32'd0, 32'd1); ea = '0; end
    else ea = sb_a.pop_front();
    if (sb_b.size() == 0) begin check("B_sb_empty", 32'd0, 32'd1); eb = '0; end
    else eb = sb_b.pop_front();
    if (sb_c.size() == 0) begin check("C_sb_empty", 32'd0, 32'd1); ec = '0; end
    else ec = sb_c.pop_front();
    eval_inst("A", ma, if_a.row, if_a.col, if_a.visible, if_a.frame_tick,
              if_a.hsync, if_a.vsync, if_a.rgb_out, ea);
    eval_inst("B", mb, if_b.row, if_b.col, if_b.visible, if_b.frame_tick,
              if_b.hsync, if_b.vsync, if_b.rgb_out, eb);
    eval_inst("C", mc, if_c.row, if_c.col, if_c.visible, if_c.frame_tick,
              if_c.hsync, if_c.vsync, if_c.rgb_out, ec);
    if (!cur_rst && n == 800)
      check("A_line_wrap", 32'({if_a.row, if_a.col}), 32'({10'd1, 10'd0}));
    if (g >= WIN0 && g < WIN0 + 800) begin
      a_hs += int'(if_a.hsync == 1'b0);
      a_vs += int'(if_a.vsync == 1'b0);
    end
    if (g >= WIN0 && g < WIN0 + 150) begin
      b_ft += int'(if_b.frame_tick);
      b_hs += int'(if_b.hsync == 1'b0);
      b_vs += int'(if_b.vsync == 1'b0);
      c_ft += int'(if_c.frame_tick);
      c_hs += int'(if_c.hsync == 1'b1);
      c_vs += int'(if_c.vsync == 1'b1);
    end
    if (track_ft && ft_lat < 0 && if_b.frame_tick === 1'b1) ft_lat = n;
    sb_a.push_back(s1_exp(cfg_a, ma, nrgb, nrst));
    sb_b.push_back(s1_exp(cfg_b, mb, nrgb, nrst));
    sb_c.push_back(s1_exp(cfg_c, mc, nrgb, nrst));
    rst     = nrst;
    cur_rst = nrst;
    rgb_drv = nrgb;
  endtask

  initial begin
    rst     = 1'b1;
    cur_rst = 1'b1;
    rgb_drv = 3'b000;
    sb_a.push_back(s1_exp(cfg_a, model_s0(cfg_a, 0), 3'b000, 1'b1));
    sb_b.push_back(s1_exp(cfg_b, model_s0(cfg_b, 0), 3'b000, 1'b1));
    sb_c.push_back(s1_exp(cfg_c, model_s0(cfg_c, 0), 3'b000, 1'b1));

    tick(1'b1, 3'($urandom_range(0, 7)));
    tick(1'b0, 3'($urandom_range(0, 7)));
    // Reset state
    check("A_rst_rowcol", 32'({if_a.row, if_a.col}), 32'd0);
    check("A_rst_vis_ft", 32'({if_a.visible, if_a.frame_tick}), 32'b10);
    check("A_rst_stage1", 32'({if_a.hsync, if_a.vsync, if_a.rgb_out}), 32'b11000);
    check("C_rst_stage1", 32'({if_c.hsync, if_c.vsync, if_c.rgb_out}), 32'b00000);

    // Free run with random colour
    for (int i = 0; i < 2500; i++) tick(1'b0, 3'($urandom_range(0, 7)));
    check("A_hsync_per_line", 32'(a_hs), 32'd96);
    check("A_vsync_rows1_2", 32'(a_vs), 32'd0);
    check("B_ft_per_frame", 32'(b_ft), 32'd1);
    check("B_hsync_per_frame", 32'(b_hs), 32'd30);
    check("B_vsync_per_frame", 32'(b_vs), 32'd30);
    check("C_ft_per_frame", 32'(c_ft), 32'd1);
    check("C_hsync_per_frame", 32'(c_hs), 32'd30);
    check("C_vsync_per_frame", 32'(c_vs), 32'd30);

    // Mid-frame reset with B at row 3, col 4
    for (int i = 0; i < 200 && (n % 150) != 48; i++) tick(1'b0, 3'($urandom_range(0, 7)));
    tick(1'b1, 3'b101);
    check("B_pre_rst_pos", 32'({if_b.row, if_b.col}), 32'({10'd3, 10'd4}));
    tick(1'b0, 3'b101);
    check("B_mid_rst_rowcol", 32'({if_b.row, if_b.col}), 32'd0);
    check("B_mid_rst_stage1", 32'({if_b.hsync, if_b.vsync, if_b.rgb_out}), 32'b11000);
    check("B_mid_rst_vis_ft", 32'({if_b.visible, if_b.frame_tick}), 32'b10);
    track_ft = 1'b1;
    ft_lat   = -1;

    // Constant colour after reset
    for (int i = 0; i < 1000; i++) tick(1'b0, 3'b101);
    check("B_ft_after_rst", 32'(ft_lat), 32'd75);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish (cycle %0d)", g);
    $fatal(1, "watchdog");
  end

endmodule
